// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: data register -> shift register -> 8N1 serial frame.
// Each serial bit is held for CLKS_PER_BIT clocks; Serial_out is driven from a flop.
`timescale 1ns/1ps
module uart_tx #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] uart_tx_data_Bus,
  input  logic                 Load_XMT_datareg,
  input  logic                 Byte_ready,
  input  logic                 T_byte,
  output logic                 Serial_out
);

  localparam int FRAME_BITS = WORD_SIZE + 2;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    SENDING = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;
  logic [WORD_SIZE-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic                  serial_q, serial_d;
  logic [FRAME_BITS-1:0] frame;

  // Complete frame, index 0 = start bit, last index = stop bit.
  assign frame = {1'b1, shift_q, 1'b0};

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    data_d   = Load_XMT_datareg ? uart_tx_data_Bus : data_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    serial_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (Byte_ready) begin
          // A same-cycle load bypasses the data register so the new byte is framed.
          shift_d = Load_XMT_datareg ? uart_tx_data_Bus : data_q;
          state_d = WAITING;
        end
      end

      WAITING: begin
        if (T_byte) begin
          state_d  = SENDING;
          bit_d    = '0;
          baud_d   = '0;
          serial_d = 1'b0;
        end
      end

      SENDING: begin
        serial_d = serial_q;
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d  = IDLE;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 1'b1;
            serial_d = frame[bit_d];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q  <= IDLE;
      // NOTE: the byte registers are plain flops, not a memory array, so clearing them on reset is cheap and keeps the line deterministic.
      data_q   <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      serial_q <= serial_d;
    end
  end

  assign Serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at 1 clock/bit, one at 4 clocks/bit,
// both driven from the same stimulus; outputs sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] bus;
  logic       load;
  logic       br;
  logic       tb;
  logic       serial1;
  logic       serial4;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.WORD_SIZE(8), .CLKS_PER_BIT(1)) dut1 (
    .clock            (clock),
    .reset            (reset),
    .uart_tx_data_Bus (bus),
    .Load_XMT_datareg (load),
    .Byte_ready       (br),
    .T_byte           (tb),
    .Serial_out       (serial1)
  );

  uart_tx #(.WORD_SIZE(8), .CLKS_PER_BIT(4)) dut4 (
    .clock            (clock),
    .reset            (reset),
    .uart_tx_data_Bus (bus),
    .Load_XMT_datareg (load),
    .Byte_ready       (br),
    .T_byte           (tb),
    .Serial_out       (serial4)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected line levels for one frame, index 0 first on the wire.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    load  = 1'b0;
    br    = 1'b0;
    tb    = 1'b0;
    bus   = 8'h00;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus  = 8'($urandom);
      load = 1'($urandom);
      br   = 1'($urandom);
      tb   = 1'($urandom);
      step();
      checks++;
      if (serial1 !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: Serial_out=%b expected 1", i, serial1);
      end
    end
    reset = 1'b1;
    load  = 1'b0;
    br    = 1'b0;
    tb    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (serial1 !== 1'b1) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: Serial_out=%b expected 1", i, serial1);
      end
    end
  endtask

  task automatic test_tbyte_in_idle();
    tb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (serial1 !== 1'b1) begin
        failures++;
        $display("FAIL tbyte_idle cycle %0d: Serial_out=%b expected 1", i, serial1);
      end
    end
    tb = 1'b0;
  endtask

  task automatic test_single_byte();
    logic [9:0] exp;
    exp  = frame_bits(8'h41);
    load = 1'b1;
    br   = 1'b1;
    bus  = 8'h41;
    step();
    checks++;
    if (serial1 !== 1'b1) begin
      failures++;
      $display("FAIL single_waiting: Serial_out=%b expected 1", serial1);
    end
    load = 1'b0;
    br   = 1'b0;
    tb   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) tb = 1'b0;
      checks++;
      if (serial1 !== exp[i]) begin
        failures++;
        $display("FAIL single_A bit %0d: Serial_out=%b expected %b", i, serial1, exp[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (serial1 !== 1'b1) begin
        failures++;
        $display("FAIL single_after cycle %0d: Serial_out=%b expected 1", i, serial1);
      end
    end
  endtask

  task automatic test_separate_load();
    logic [9:0] exp;
    exp  = frame_bits(8'hA5);
    load = 1'b1;
    bus  = 8'hA5;
    step();
    load = 1'b0;
    bus  = 8'h00;
    step();
    step();
    br = 1'b1;
    step();
    br = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (serial1 !== 1'b1) begin
        failures++;
        $display("FAIL sep_waiting cycle %0d: Serial_out=%b expected 1", i, serial1);
      end
    end
    tb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) tb = 1'b0;
      checks++;
      if (serial1 !== exp[i]) begin
        failures++;
        $display("FAIL sep_A5 bit %0d: Serial_out=%b expected %b", i, serial1, exp[i]);
      end
    end
    step();
    checks++;
    if (serial1 !== 1'b1) begin
      failures++;
      $display("FAIL sep_after: Serial_out=%b expected 1", serial1);
    end
  endtask

  task automatic test_mid_frame();
    logic [9:0] exp;
    logic [9:0] exp_ff;
    exp    = frame_bits(8'h3C);
    exp_ff = frame_bits(8'hFF);
    load = 1'b1;
    br   = 1'b1;
    bus  = 8'h3C;
    step();
    load = 1'b0;
    br   = 1'b0;
    tb   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      case (i)
        0: tb = 1'b0;
        2: begin load = 1'b1; bus = 8'hFF; br = 1'b1; tb = 1'b1; end
        3: begin load = 1'b0; br = 1'b0; tb = 1'b0; end
        4: br = 1'b1;
        5: begin br = 1'b0; tb = 1'b1; end
        6: tb = 1'b0;
        default: ;
      endcase
      checks++;
      if (serial1 !== exp[i]) begin
        failures++;
        $display("FAIL mid_3C bit %0d: Serial_out=%b expected %b", i, serial1, exp[i]);
      end
    end
    step();
    br = 1'b1;
    step();
    br = 1'b0;
    tb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) tb = 1'b0;
      checks++;
      if (serial1 !== exp_ff[i]) begin
        failures++;
        $display("FAIL mid_next_FF bit %0d: Serial_out=%b expected %b", i, serial1, exp_ff[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    exp  = frame_bits(8'h96);
    load = 1'b1;
    bus  = 8'h96;
    br   = 1'b1;
    tb   = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (serial1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_waiting: Serial_out=%b expected 1", serial1);
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 10; i++) begin
        step();
        checks++;
        if (serial1 !== exp[i]) begin
          failures++;
          $display("FAIL b2b frame %0d bit %0d: Serial_out=%b expected %b", f, i, serial1, exp[i]);
        end
      end
      if (f == 0) begin
        for (int g = 0; g < 2; g++) begin
          step();
          checks++;
          if (serial1 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap cycle %0d: Serial_out=%b expected 1", g, serial1);
          end
        end
      end
    end
    br = 1'b0;
    tb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (serial1 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_after cycle %0d: Serial_out=%b expected 1", i, serial1);
      end
    end
  endtask

  task automatic test_cpb4();
    logic exp;
    apply_reset();
    load = 1'b1;
    br   = 1'b1;
    bus  = 8'h00;
    step();
    load = 1'b0;
    br   = 1'b0;
    tb   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) tb = 1'b0;
      exp = (i < 36) ? 1'b0 : 1'b1;
      checks++;
      if (serial4 !== exp) begin
        failures++;
        $display("FAIL cpb4_00 cycle %0d: Serial_out=%b expected %b", i, serial4, exp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (serial4 !== 1'b1) begin
        failures++;
        $display("FAIL cpb4_after cycle %0d: Serial_out=%b expected 1", i, serial4);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp;
    exp  = frame_bits(8'h55);
    load = 1'b1;
    br   = 1'b1;
    bus  = 8'h55;
    step();
    load = 1'b0;
    br   = 1'b0;
    tb   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) tb = 1'b0;
      checks++;
      if (serial1 !== exp[i]) begin
        failures++;
        $display("FAIL rmf_pre bit %0d: Serial_out=%b expected %b", i, serial1, exp[i]);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (serial1 !== 1'b1) begin
      failures++;
      $display("FAIL rmf_abort: Serial_out=%b expected 1", serial1);
    end
    reset = 1'b1;
    tb    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (serial1 !== 1'b1) begin
        failures++;
        $display("FAIL rmf_idle cycle %0d: Serial_out=%b expected 1", i, serial1);
      end
    end
    tb   = 1'b0;
    load = 1'b1;
    br   = 1'b1;
    step();
    load = 1'b0;
    br   = 1'b0;
    tb   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) tb = 1'b0;
      checks++;
      if (serial1 !== exp[i]) begin
        failures++;
        $display("FAIL rmf_resend bit %0d: Serial_out=%b expected %b", i, serial1, exp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (serial1 !== 1'b1) begin
        failures++;
        $display("FAIL rmf_after cycle %0d: Serial_out=%b expected 1", i, serial1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    br    = 1'b0;
    tb    = 1'b0;
    bus   = 8'h00;
    step();
    test_reset();
    test_tbyte_in_idle();
    test_single_byte();
    test_separate_load();
    test_mid_frame();
    test_back_to_back();
    test_cpb4();
    apply_reset();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
